// File: rtl/gowin_tl_tx_pktbuf_pkg.sv
// rtl/gowin_tl_tx_pktbuf_pkg.sv - beat type, sizes and output FSM states for the TX packet buffer
package gowin_tl_pkg;

  localparam int TL_BEAT_W        = 266;
  localparam int TL_MAX_TLP_BEATS = 33;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [7:0]   valid;
    logic [255:0] data;
  } tl_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/gowin_tl_tx_pktbuf_fifo.sv
// rtl/gowin_tl_tx_pktbuf_fifo.sv - first-word-fall-through beat FIFO, RAM array plus registered head
module tl_beat_fifo
  import gowin_tl_pkg::*;
#(
  parameter int C_DEPTH = 64,
  parameter int C_CNT_W = $clog2(C_DEPTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  tl_beat_t din,
  input  logic     pop,
  input  logic     flush,
  output logic     full,
  output logic     empty,
  output tl_beat_t dout
);

  localparam int A_W = C_CNT_W - 1;
  localparam logic [C_CNT_W-1:0] PTR_ONE = C_CNT_W'(1);

  logic [TL_BEAT_W-1:0] mem [C_DEPTH];
  logic [C_CNT_W-1:0]   wptr, rptr;
  logic                 head_vld, mem_empty, load;

  assign mem_empty = (wptr == rptr);
  assign full      = ((wptr ^ rptr) == {1'b1, {A_W{1'b0}}});
  assign empty     = !head_vld;
  // The head register refills from the array whenever it is empty or being popped.
  assign load      = !mem_empty && (!head_vld || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[A_W-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      head_vld <= 1'b0;
      dout     <= '0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      head_vld <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (load) begin
        dout     <= tl_beat_t'(mem[rptr[A_W-1:0]]);
        rptr     <= rptr + PTR_ONE;
        head_vld <= 1'b1;
      end else if (pop) begin
        head_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gowin_tl_tx_pktbuf.sv
// rtl/gowin_tl_tx_pktbuf.sv - store-and-forward TX TLP buffer feeding the PCIe core tl_tx port
module gowin_tl_tx_pktbuf
  import gowin_tl_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 256,
  parameter int C_DEPTH          = 64,
  parameter int C_CNT_W          = $clog2(C_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_en,
  output logic                        s_ready,
  input  logic                        s_sop,
  input  logic                        s_eop,
  input  logic [C_PCI_DATA_WIDTH-1:0] s_data,
  input  logic [7:0]                  s_valid,
  output logic                        tl_tx_sop,
  output logic                        tl_tx_eop,
  output logic [C_PCI_DATA_WIDTH-1:0] tl_tx_data,
  output logic [7:0]                  tl_tx_valid,
  input  logic                        tl_tx_wait,
  output logic [C_CNT_W-1:0]          pkt_cnt,
  output logic                        err_framing,
  output logic                        err_oversize
);

  if (C_DEPTH < TL_MAX_TLP_BEATS || C_PCI_DATA_WIDTH != 256) begin : g_bad_cfg
    $error("gowin_tl_tx_pktbuf: unsupported C_DEPTH or C_PCI_DATA_WIDTH");
  end

  tx_state_e state, state_nxt;
  tl_beat_t  din, head;
  logic      in_pkt, dropping, rdy_en;
  logic      full, head_empty, take, wr, accept, oversize, inc, dec;

  // Beats are still taken (and discarded) while dropping so the upstream can reach its EOP.
  assign s_ready  = rdy_en && !full;
  assign take     = s_en && s_ready;
  assign wr       = take && !dropping && (in_pkt || s_sop);
  assign oversize = full && in_pkt && (pkt_cnt == '0);
  assign accept   = (state == SEND) && !head_empty && !tl_tx_wait;
  assign inc      = wr && s_eop;
  assign dec      = accept && head.eop;

  always_comb begin
    din       = '0;
    din.sop   = s_sop && !in_pkt;
    din.eop   = s_eop;
    din.valid = s_valid;
    din.data  = s_data;
  end

  tl_beat_fifo #(.C_DEPTH(C_DEPTH), .C_CNT_W(C_CNT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr),
    .din   (din),
    .pop   (accept),
    .flush (oversize),
    .full  (full),
    .empty (head_empty),
    .dout  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en       <= 1'b0;
      in_pkt       <= 1'b0;
      dropping     <= 1'b0;
      err_framing  <= 1'b0;
      err_oversize <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (oversize) begin
        dropping     <= 1'b1;
        in_pkt       <= 1'b0;
        err_oversize <= 1'b1;
      end else if (dropping) begin
        if (take && s_eop) dropping <= 1'b0;
      end else if (wr) begin
        in_pkt <= !s_eop;
      end
      if ((take && !dropping && !in_pkt && !s_sop) || (wr && in_pkt && s_sop))
        err_framing <= 1'b1;
      case ({inc, dec})
        2'b10:   pkt_cnt <= pkt_cnt + C_CNT_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - C_CNT_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pkt_cnt != '0) state_nxt = SEND;
      SEND:    if (dec && pkt_cnt == C_CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tl_tx_sop   = 1'b0;
    tl_tx_eop   = 1'b0;
    tl_tx_valid = '0;
    tl_tx_data  = '0;
    if (state == SEND && !head_empty) begin
      tl_tx_sop   = head.sop;
      tl_tx_eop   = head.eop;
      tl_tx_valid = head.valid;
      tl_tx_data  = head.data;
    end
  end

endmodule

// File: tb/tb_gowin_tl_tx_pktbuf.sv
// tb/tb_gowin_tl_tx_pktbuf.sv - scoreboard bench for the TX packet buffer
module tb_gowin_tl_tx_pktbuf;
  import gowin_tl_pkg::*;

  localparam int DEPTH = 64;
  localparam int CW    = 7;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_en, s_ready, s_sop, s_eop;
  logic [255:0]   s_data;
  logic [7:0]     s_valid;
  logic           tl_tx_sop, tl_tx_eop, tl_tx_wait;
  logic [255:0]   tl_tx_data;
  logic [7:0]     tl_tx_valid;
  logic [CW-1:0]  pkt_cnt;
  logic           err_framing, err_oversize;

  always #5 clk = ~clk;

  gowin_tl_tx_pktbuf #(.C_PCI_DATA_WIDTH(256), .C_DEPTH(DEPTH), .C_CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_en         (s_en),
    .s_ready      (s_ready),
    .s_sop        (s_sop),
    .s_eop        (s_eop),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .tl_tx_sop    (tl_tx_sop),
    .tl_tx_eop    (tl_tx_eop),
    .tl_tx_data   (tl_tx_data),
    .tl_tx_valid  (tl_tx_valid),
    .tl_tx_wait   (tl_tx_wait),
    .pkt_cnt      (pkt_cnt),
    .err_framing  (err_framing),
    .err_oversize (err_oversize)
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [265:0] sb[$];
  int           out_cycles = 0, gaps = 0, holds = 0, cyc = 0;
  int           last_acc = -10, prev_acc = -10, peak = 0;
  logic         out_in_pkt = 1'b0, prev_wait_vld = 1'b0;
  logic [265:0] prev_beat, mon_cur;

  task automatic chk(input string tag, input logic [265:0] obs, input logic [265:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on accept, hold stability under wait, gap and cycle accounting.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      out_in_pkt    = 1'b0;
      prev_wait_vld = 1'b0;
    end else begin
      mon_cur = {tl_tx_sop, tl_tx_eop, tl_tx_valid, tl_tx_data};
      if (prev_wait_vld) begin
        chk("hold_stable", mon_cur, prev_beat);
        holds++;
      end
      if (int'(pkt_cnt) > peak) peak = int'(pkt_cnt);
      if (tl_tx_valid != 8'h00) begin
        out_cycles++;
        if (!tl_tx_wait) begin
          if (sb.size() == 0) chk("unexpected_beat", mon_cur, 266'd0);
          else                chk("beat", mon_cur, sb.pop_front());
          prev_acc   = last_acc;
          last_acc   = cyc;
          out_in_pkt = !tl_tx_eop;
        end
        prev_wait_vld = tl_tx_wait;
        prev_beat     = mon_cur;
      end else begin
        if (out_in_pkt) gaps++;
        prev_wait_vld = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic sop, input logic eop, input logic [7:0] vld,
                           input logic store, input logic exp_sop);
    logic [255:0] d;
    int t;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    s_en = 1'b1; s_sop = sop; s_eop = eop; s_valid = vld; s_data = d;
    t = 0;
    while (!s_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready) chk("s_ready_timeout", 266'(s_ready), 266'd1);
    @(posedge clk); #1;
    s_en = 1'b0;
    if (store) sb.push_back({exp_sop, eop, vld, d});
  endtask

  task automatic send_pkt(input int n, input logic [7:0] last_vld, input logic store);
    for (int i = 0; i < n; i++)
      send_beat(i == 0, i == n - 1, (i == n - 1) ? last_vld : 8'hFF, store, i == 0);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || pkt_cnt != '0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_sb_left"}, 266'(sb.size()), 266'd0);
    chk({tag, "_pkt_cnt"}, 266'(pkt_cnt), 266'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  int o0, h0;

  initial begin
    rst_n = 1'b0; s_en = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    s_data = '0; s_valid = '0; tl_tx_wait = 1'b0;
    #12;
    chk("rst_s_ready", 266'(s_ready), 266'd0);
    chk("rst_out", 266'({tl_tx_sop, tl_tx_eop, tl_tx_valid, tl_tx_data}), 266'd0);
    chk("rst_pkt_cnt", 266'(pkt_cnt), 266'd0);
    chk("rst_errs", 266'({err_framing, err_oversize}), 266'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 3-beat TLP, latency and contiguity
    o0 = out_cycles;
    send_pkt(3, 8'h0F, 1'b1);
    @(negedge clk);
    chk("t1_lat_pre", 266'(tl_tx_valid), 266'd0);
    @(negedge clk);
    chk("t1_lat_first", 266'({tl_tx_sop, tl_tx_valid}), 266'({1'b1, 8'hFF}));
    chk("t1_pkt_cnt_1", 266'(pkt_cnt), 266'd1);
    drain("t1");
    chk("t1_cycles", 266'(out_cycles - o0), 266'd3);
    chk("t1_gaps", 266'(gaps), 266'd0);

    // 2: upstream gap before the EOP beat
    o0 = out_cycles;
    send_beat(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
    send_beat(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("t2_no_early", 266'(tl_tx_valid), 266'd0);
    end
    @(posedge clk); #1;
    send_beat(1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    drain("t2");
    chk("t2_cycles", 266'(out_cycles - o0), 266'd3);
    chk("t2_gaps", 266'(gaps), 266'd0);

    // 3: 33-beat TLP, core wait for 4 cycles on beat 1
    o0 = out_cycles; h0 = holds;
    send_pkt(33, 8'hFF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tl_tx_wait = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    tl_tx_wait = 1'b0;
    drain("t3");
    chk("t3_cycles", 266'(out_cycles - o0), 266'd37);
    chk("t3_holds", 266'(holds - h0), 266'd4);
    chk("t3_gaps", 266'(gaps), 266'd0);

    // 4: two single-beat TLPs back to back
    peak = 0;
    send_beat(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    send_beat(1'b1, 1'b1, 8'h07, 1'b1, 1'b1);
    drain("t4");
    chk("t4_consecutive", 266'(last_acc - prev_acc), 266'd1);
    chk("t4_peak", 266'(peak), 266'd2);

    // 5: framing errors
    chk("t5_err_pre", 266'(err_framing), 266'd0);
    send_beat(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t5_err_nonsop", 266'(err_framing), 266'd1);
    send_beat(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
    send_beat(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    send_beat(1'b0, 1'b1, 8'h03, 1'b1, 1'b0);
    drain("t5");
    chk("t5_no_oversize", 266'(err_oversize), 266'd0);

    // 6: oversize TLP, recovery, then reset mid-packet
    o0 = out_cycles;
    send_pkt(70, 8'hFF, 1'b0);
    chk("t6_err_oversize", 266'(err_oversize), 266'd1);
    repeat (5) @(negedge clk);
    chk("t6_no_output", 266'(out_cycles - o0), 266'd0);
    chk("t6_pkt_cnt", 266'(pkt_cnt), 266'd0);
    chk("t6_framing_sticky", 266'(err_framing), 266'd1);
    @(posedge clk); #1;
    send_pkt(2, 8'h01, 1'b1);
    drain("t6_after");
    chk("t6_after_cycles", 266'(out_cycles - o0), 266'd2);

    tl_tx_wait = 1'b1;
    send_beat(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    send_beat(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_held_before_rst", 266'(tl_tx_valid), 266'hFF);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", 266'({tl_tx_sop, tl_tx_eop, tl_tx_valid, tl_tx_data}), 266'd0);
    chk("t6_rst_pkt_cnt", 266'(pkt_cnt), 266'd0);
    chk("t6_rst_errs", 266'({err_framing, err_oversize}), 266'd0);
    chk("t6_rst_s_ready", 266'(s_ready), 266'd0);
    sb.delete();
    tl_tx_wait = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    o0 = out_cycles;
    send_beat(1'b1, 1'b1, 8'h0F, 1'b1, 1'b1);
    drain("t6_post_rst");
    chk("t6_post_rst_cycles", 266'(out_cycles - o0), 266'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
